// File: rtl/ksa_add_arbiter_pkg.sv
// Shared constants for the shared Kogge-Stone adder arbiter.
// Defines package ksa_arb_defs (data width, counter width, pointer width helper).
package ksa_arb_defs;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  function automatic int ptr_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_t;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              carry;
  } res_t;

endpackage

// File: rtl/ksa_add_arbiter_rr_grant.sv
// Round-robin grant: first valid requester at or after ptr, wrapping mod NREQ.
module rr_grant #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    int          k;
    logic [IDW-1:0] kk;
    logic        found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    kk    = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      kk = IDW'(k);
      if (!found && valid[kk]) begin
        found     = 1'b1;
        grant[kk] = 1'b1;
        idx       = kk;
      end
    end
  end

endmodule

// File: rtl/ksa_top_32b.sv
// 32-bit Kogge-Stone adder with carry-in; purely combinational.
// Carry-in is folded into bit 0's generate so the prefix tree yields every carry.
module ksa_top_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [5:0][31:0] g;
  logic [5:0][31:0] p;

  assign p[0] = a ^ b;
  assign g[0] = (a & b) | {31'b0, (a[0] ^ b[0]) & cin};

  for (genvar l = 0; l < 5; l++) begin : g_lvl
    localparam int D = 1 << l;
    for (genvar i = 0; i < 32; i++) begin : g_bit
      if (i >= D) begin : g_op
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-D]);
        assign p[l+1][i] = p[l][i] & p[l][i-D];
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        assign p[l+1][i] = p[l][i];
      end
    end
  end

  assign sum  = p[0] ^ {g[5][30:0], cin};
  assign cout = g[5][31];

endmodule

// File: rtl/ksa_add_arbiter.sv
// Shares one ksa_top_32b among NREQ requesters: RR arbiter, operand reg, result reg.
// Optional subtract support via `define KSA_ARB_SUB_EN.
module ksa_add_arbiter
  import ksa_arb_defs::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [NREQ*DATA_W-1:0] i_req_a,
  input  logic [NREQ*DATA_W-1:0] i_req_b,
`ifdef KSA_ARB_SUB_EN
  input  logic [NREQ-1:0]        i_req_sub,
`endif
  output logic [NREQ-1:0]        o_req_ready,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [DATA_W-1:0]      o_res_sum,
  output logic                   o_res_carry,
  output logic [IDW-1:0]         o_res_id,
  output logic                   o_busy,
  output logic [CNT_W-1:0]       o_op_count
);

  logic [1:0]      vld_pipe;   // [0] operand stage, [1] result stage
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            s1_load, s0_load, accept;
  op_t             sel_op, s0_op;
  logic [IDW-1:0]  s0_id;
  logic            s0_sub;
  res_t            add_res;

  rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .valid (i_req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign s1_load     = !vld_pipe[1] || i_res_ready;
  assign s0_load     = !vld_pipe[0] || s1_load;
  assign o_req_ready = s0_load ? grant : '0;
  assign accept      = |(i_req_valid & o_req_ready);

  always_comb begin
    sel_op = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gidx == IDW'(k)) begin
        sel_op.a = i_req_a[k*DATA_W +: DATA_W];
        sel_op.b = i_req_b[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef KSA_ARB_SUB_EN
  logic sel_sub;
  always_comb begin
    sel_sub = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (gidx == IDW'(k)) sel_sub = i_req_sub[k];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            s0_sub <= 1'b0;
    else if (s0_load && accept) s0_sub <= sel_sub;
  end
`else
  assign s0_sub = 1'b0;
`endif

  // Subtract = A + ~B + 1; the stage-0 flag drives both inversion and carry-in.
  ksa_top_32b u_ksa (
    .a    (s0_op.a),
    .b    (s0_sub ? ~s0_op.b : s0_op.b),
    .cin  (s0_sub),
    .sum  (add_res.sum),
    .cout (add_res.carry)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe    <= '0;
      ptr         <= '0;
      s0_op       <= '0;
      s0_id       <= '0;
      o_res_sum   <= '0;
      o_res_carry <= 1'b0;
      o_res_id    <= '0;
      o_op_count  <= '0;
    end else begin
      if (s0_load) begin
        vld_pipe[0] <= accept;
        if (accept) begin
          s0_op <= sel_op;
          s0_id <= gidx;
          ptr   <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
        end
      end
      if (s1_load) begin
        vld_pipe[1] <= vld_pipe[0];
        if (vld_pipe[0]) begin
          o_res_sum   <= add_res.sum;
          o_res_carry <= add_res.carry;
          o_res_id    <= s0_id;
        end
      end
      if (vld_pipe[1] && i_res_ready) o_op_count <= o_op_count + CNT_W'(1);
    end
  end

  assign o_res_valid = vld_pipe[1];
  assign o_busy      = |vld_pipe;

endmodule

// File: tb/tb_ksa_add_arbiter.sv
// Scoreboard bench for ksa_add_arbiter: stimulus pushes expected results, monitor pops.
module tb_ksa_add_arbiter;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        carry;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   vld = '0;
  logic [127:0] a_bus = '0, b_bus = '0;
  logic [3:0]   sub_bus = '0;
  logic         res_ready = 1'b1;
  logic [3:0]   o_req_ready;
  logic         o_res_valid, o_res_carry, o_busy;
  logic [31:0]  o_res_sum;
  logic [1:0]   o_res_id;
  logic [15:0]  o_op_count;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  ksa_add_arbiter #(.NREQ(4), .IDW(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (vld),
    .i_req_a     (a_bus),
    .i_req_b     (b_bus),
`ifdef KSA_ARB_SUB_EN
    .i_req_sub   (sub_bus),
`endif
    .o_req_ready (o_req_ready),
    .o_res_valid (o_res_valid),
    .i_res_ready (res_ready),
    .o_res_sum   (o_res_sum),
    .o_res_carry (o_res_carry),
    .o_res_id    (o_res_id),
    .o_busy      (o_busy),
    .o_op_count  (o_op_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every result handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && o_res_valid && res_ready) begin
      if (q.size() == 0) chk("unexpected_result", {62'b0, o_res_id}, 64'hFFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("res_id", {62'b0, o_res_id}, {62'b0, e.id});
        chk("res_sum", {32'b0, o_res_sum}, {32'b0, e.sum});
        chk("res_carry", {63'b0, o_res_carry}, {63'b0, e.carry});
      end
      exp_cnt++;
    end
  end

  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
    a_bus[k*32 +: 32] = a;
    b_bus[k*32 +: 32] = b;
  endtask

  task automatic push(input int id, input logic [31:0] sum, input logic carry);
    exp_t e;
    e.id = 2'(id); e.sum = sum; e.carry = carry;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin tick(); n++; end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'h0);
      q.delete();
    end
  endtask

  logic [31:0] fa[4] = '{32'h10, 32'h20, 32'h30, 32'h40};
  logic [31:0] fb[4] = '{32'h0, 32'h1, 32'h2, 32'h3};
  logic [31:0] fs[4] = '{32'h10, 32'h21, 32'h32, 32'h43};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {60'b0, o_req_ready}, 64'h0);
    chk("rst_res_valid", {63'b0, o_res_valid}, 64'h0);
    chk("rst_busy", {63'b0, o_busy}, 64'h0);
    chk("rst_count", {48'b0, o_op_count}, 64'h0);
    rst_n = 1'b1;

    // Single request: 5 + 3, two-cycle latency
    set_op(0, 32'h5, 32'h3);
    vld = 4'b0001;
    #1 chk("single_ready", {60'b0, o_req_ready}, 64'h1);
    push(0, 32'h8, 1'b0);
    tick();
    vld = '0;
    chk("single_lat_s0", {63'b0, o_res_valid}, 64'h0);
    chk("single_busy", {63'b0, o_busy}, 64'h1);
    tick();
    chk("single_lat_s1", {63'b0, o_res_valid}, 64'h1);
    drain();
    chk("single_count", {48'b0, o_op_count}, 64'd1);

    // Fairness: pointer is at 1 after the single request, so order is 1,2,3,0,...
    for (int k = 0; k < 4; k++) set_op(k, fa[k], fb[k]);
    for (int c = 0; c < 8; c++) begin
      int k;
      k = (c + 1) % 4;
      vld = 4'hF;
      #1 chk("fair_grant", {60'b0, o_req_ready}, 64'(4'b0001 << k));
      push(k, fs[k], 1'b0);
      tick();
    end
    vld = '0;
    drain();
    chk("fair_count", {48'b0, o_op_count}, 64'd9);
    chk("fair_idle", {63'b0, o_busy}, 64'h0);

    // Carry out, pointer at 1: req2 then req3
    set_op(2, 32'hFFFF_FFFF, 32'h1);
    set_op(3, 32'h7FFF_FFFF, 32'h1);
    vld = 4'b1100;
    #1 chk("carry_grant2", {60'b0, o_req_ready}, 64'h4);
    push(2, 32'h0, 1'b1);
    tick();
    vld = 4'b1000;
    #1 chk("carry_grant3", {60'b0, o_req_ready}, 64'h8);
    push(3, 32'h8000_0000, 1'b0);
    tick();
    vld = '0;
    drain();
    chk("carry_count", {48'b0, o_op_count}, 64'd11);

    // Counter wrap: stream single-requester ops up to 0xFFFF, then one more
    begin
      int n;
      n = 65535 - exp_cnt;
      for (int i = 0; i < n; i++) begin
        set_op(0, 32'(i), 32'h1);
        vld = 4'b0001;
        push(0, 32'(i) + 32'h1, 1'b0);
        tick();
      end
      vld = '0;
      drain();
      chk("wrap_ffff", {48'b0, o_op_count}, 64'hFFFF);
      set_op(0, 32'hA, 32'hB);
      vld = 4'b0001;
      push(0, 32'h15, 1'b0);
      tick();
      vld = '0;
      drain();
      chk("wrap_zero", {48'b0, o_op_count}, 64'h0);
    end

    // Back-pressure: two accepts fill both stages, then ready stays low
    res_ready = 1'b0;
    set_op(1, 32'd100, 32'd23);
    set_op(2, 32'h0000_FFFF, 32'h1);
    vld = 4'b0110;
    #1 chk("bp_grant1", {60'b0, o_req_ready}, 64'h2);
    push(1, 32'd123, 1'b0);
    tick();
    vld = 4'b0100;
    #1 chk("bp_grant2", {60'b0, o_req_ready}, 64'h4);
    push(2, 32'h0001_0000, 1'b0);
    tick();
    vld = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_stall_ready", {60'b0, o_req_ready}, 64'h0);
      tick();
    end
    chk("bp_busy", {63'b0, o_busy}, 64'h1);
    vld = '0;
    res_ready = 1'b1;
    drain();
    chk("bp_count", {48'b0, o_op_count}, 64'd2);

    // Reset with both stages full; pointer is at 3 so req0 then req1 are taken
    res_ready = 1'b0;
    set_op(0, 32'h1, 32'h1);
    set_op(1, 32'h2, 32'h2);
    vld = 4'b0011;
    tick();
    vld = 4'b0010;
    tick();
    vld = '0;
    chk("pre_rst_valid", {63'b0, o_res_valid}, 64'h1);
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    chk("rst_mid_valid", {63'b0, o_res_valid}, 64'h0);
    chk("rst_mid_busy", {63'b0, o_busy}, 64'h0);
    chk("rst_mid_count", {48'b0, o_op_count}, 64'h0);
    chk("rst_mid_sum", {32'b0, o_res_sum}, 64'h0);
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    set_op(2, 32'h1234_0000, 32'h0000_5678);
    set_op(3, 32'h1, 32'h2);
    vld = 4'b1100;
    #1 chk("post_rst_grant", {60'b0, o_req_ready}, 64'h4);
    push(2, 32'h1234_5678, 1'b0);
    tick();
    vld = 4'b1000;
    push(3, 32'h3, 1'b0);
    tick();
    vld = '0;
    drain();
    chk("post_rst_count", {48'b0, o_op_count}, 64'd2);

`ifdef KSA_ARB_SUB_EN
    // Subtract on req0 (pointer back at 0)
    set_op(0, 32'd10, 32'd3);
    sub_bus = 4'b0001;
    vld = 4'b0001;
    push(0, 32'd7, 1'b1);
    tick();
    set_op(0, 32'd3, 32'd10);
    push(0, 32'hFFFF_FFF9, 1'b0);
    tick();
    vld = '0;
    sub_bus = '0;
    drain();
`endif

    repeat (2) tick();
    chk("final_queue_empty", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
